// File: rtl/sp_ram_pipelined_pkg.sv
// sp_ram_pkg: shared types and helpers for the pipelined single-port RAM.
//   state_e       - controller states (CLEAR, RUN)
//   WRM_*         - codes for the data returned on a write
//   be_merge()    - byte-enable merge of an old word with new write data
package sp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int WRM_NONE        = 0;
  localparam int WRM_READ_FIRST  = 1;
  localparam int WRM_WRITE_FIRST = 2;

  // The merge helper works on a fixed maximum width so one function serves
  // every instance; callers zero-extend on the way in and truncate on the way out.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_BE_WIDTH-1:0]   be
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE_WIDTH; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sp_ram_pipelined_if.sv
// sp_ram_if: request/response bus of the pipelined single-port RAM.
//   master: drives cs, we, be, addr, wdata; observes the rest
//   slave : observes the request, drives req_ready, rdata, rd_valid,
//           rd_err, init_done
interface sp_ram_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                    cs;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    req_ready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rd_valid;
  logic                    rd_err;
  logic                    init_done;

  modport master (
    output cs, we, be, addr, wdata,
    input  req_ready, rdata, rd_valid, rd_err, init_done
  );

  modport slave (
    input  cs, we, be, addr, wdata,
    output req_ready, rdata, rd_valid, rd_err, init_done
  );
endinterface

// File: rtl/sp_ram_pipelined_array.sv
// sp_ram_array: bare single-port storage with byte-enable writes and a
// registered read port.
//   clk, rst   - clock; rst only clears the read register, never the storage
//   i_we       - write i_wdata into word i_addr under i_be
//   i_rd_en    - load the read register this cycle
//   i_rd_zero  - load zero instead of array data (out-of-range access)
//   i_ret_new  - load the merged (post-write) word instead of the old word
//   o_rdata    - read register
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic                    i_rd_en,
  input  logic                    i_rd_zero,
  input  logic                    i_ret_new,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_old    = r_mem[i_addr];
  assign w_merged = DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(w_old),
                                         MAX_DATA_WIDTH'(i_wdata),
                                         MAX_BE_WIDTH'(i_be)));

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= w_merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_rd_en) begin
      if (i_rd_zero)      r_rdata <= '0;
      else if (i_ret_new) r_rdata <= w_merged;
      else                r_rdata <= w_old;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sp_ram_pipelined.sv
// sp_ram_pipelined: single-port synchronous RAM with split read/write buses,
// byte enables, 1- or 2-cycle read latency, read-valid handshake,
// out-of-range detection and optional post-reset clear.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - sp_ram_if slave (request in, response/status out)
//
// state | meaning
// CLEAR | zeroing mem[r_clr_cnt] each cycle; requests refused
// RUN   | one request accepted per cycle
module sp_ram_pipelined
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int RD_LATENCY     = 1,   // 1 or 2
  parameter int WR_RD_MODE     = 0,   // WRM_NONE / WRM_READ_FIRST / WRM_WRITE_FIRST
  parameter int CLEAR_ON_RESET = 1
) (
  input logic     clk,
  input logic     rst,
  sp_ram_if.slave bus
);

  localparam int                    BE_WIDTH  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_req_ready;
  logic                  r_init_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CLEAR;
      r_clr_cnt   <= '0;
      r_req_ready <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          // Without a clear, CLEAR lasts exactly the first cycle after reset.
          if (CLEAR_ON_RESET == 0 || r_clr_cnt == LAST_ADDR) begin
            r_state     <= RUN;
            r_req_ready <= 1'b1;
            r_init_done <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
          end
        end
        RUN: begin
          r_req_ready <= 1'b1;
          r_init_done <= 1'b1;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  logic w_clearing;
  logic w_accept;
  logic w_in_range;
  logic w_rsp;

  assign w_clearing = (r_state == CLEAR) && (CLEAR_ON_RESET != 0);
  assign w_accept   = bus.cs && r_req_ready;
  assign w_in_range = {1'b0, bus.addr} < DEPTH_LIM;
  assign w_rsp      = w_accept && (!bus.we || (WR_RD_MODE != WRM_NONE));

  logic                  w_arr_we;
  logic [BE_WIDTH-1:0]   w_arr_be;
  logic [ADDR_WIDTH-1:0] w_arr_addr;
  logic [DATA_WIDTH-1:0] w_arr_wdata;
  logic [DATA_WIDTH-1:0] w_arr_rdata;

  // The clear sequence borrows the single array port; requests cannot
  // collide with it because req_ready is low throughout CLEAR.
  assign w_arr_we    = w_clearing || (w_accept && bus.we && w_in_range);
  assign w_arr_be    = w_clearing ? '1 : bus.be;
  assign w_arr_addr  = w_clearing ? r_clr_cnt : bus.addr;
  assign w_arr_wdata = w_clearing ? '0 : bus.wdata;

  sp_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_arr_we),
    .i_rd_en   (w_rsp),
    .i_rd_zero (!w_in_range),
    .i_ret_new (bus.we && (WR_RD_MODE == WRM_WRITE_FIRST)),
    .i_be      (w_arr_be),
    .i_addr    (w_arr_addr),
    .i_wdata   (w_arr_wdata),
    .o_rdata   (w_arr_rdata)
  );

  // Stage 1 valid/err travel alongside the array read register.
  logic r_v1;
  logic r_e1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
    end else begin
      r_v1 <= w_rsp;
      r_e1 <= w_rsp && !w_in_range;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  r_v2;
      logic                  r_e2;
      logic [DATA_WIDTH-1:0] r_rdata2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v2     <= 1'b0;
          r_e2     <= 1'b0;
          r_rdata2 <= '0;
        end else begin
          r_v2 <= r_v1;
          r_e2 <= r_e1;
          if (r_v1) r_rdata2 <= w_arr_rdata;
        end
      end

      assign bus.rd_valid = r_v2;
      assign bus.rd_err   = r_e2;
      assign bus.rdata    = r_rdata2;
    end else begin : g_lat1
      // The array read register only loads on a response, so it already
      // holds its value while rd_valid is low.
      assign bus.rd_valid = r_v1;
      assign bus.rd_err   = r_e1;
      assign bus.rdata    = w_arr_rdata;
    end
  endgenerate

  assign bus.req_ready = r_req_ready;
  assign bus.init_done = r_init_done;

endmodule

// File: doc/sp_ram_pipelined.md
Name: sp_ram_pipelined

Overview:
Next-generation single-port synchronous RAM that replaces the tristate data bus with separate write and read buses. Adds per-byte write enables, a configurable read latency (1 or 2 cycles) and a read-valid handshake. Also supports selectable old/new-data return on writes, out-of-range address detection, and an optional post-reset memory clear sequence. Used as the generic on-chip scratch/buffer memory behind bus slaves and datapath blocks.

Parameters:
ADDR_WIDTH, 4, address bits.
DATA_WIDTH, 32, word width; must be a multiple of 8.
DEPTH, 16, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
RD_LATENCY, 1, cycles from accepted request to rd_valid; legal values 1 or 2.
WR_RD_MODE, 0, data returned on a write: 0 = none, 1 = read-first (old word), 2 = write-first (merged new word).
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = no clear.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
cs  input  1  request strobe; accepted when cs && req_ready at a clk edge.
we  input  1  1 = write, 0 = read; sampled with cs.
be  input  DATA_WIDTH/8  byte enables for writes; bit i covers wdata[8i+7:8i]; ignored on reads.
addr  input  ADDR_WIDTH  word address.
wdata  input  DATA_WIDTH  write data.
req_ready  output  1  block can accept a request this cycle.
rdata  output  DATA_WIDTH  read data; meaningful only while rd_valid is high.
rd_valid  output  1  one-cycle pulse per returned word.
rd_err  output  1  qualifies rd_valid: the request address was >= DEPTH.
init_done  output  1  high once the clear sequence has finished; stays high until the next rst.

Behaviour:
- Reset (async assert): req_ready=0, rd_valid=0, rd_err=0, rdata=0, init_done=0, clear counter=0, read pipeline flushed. Memory contents are not reset by rst itself.
- FSM has two states, CLEAR and RUN.
- rst with CLEAR_ON_RESET=1: FSM enters CLEAR.
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - After the cycle that writes DEPTH-1, go to RUN; init_done and req_ready rise together.
  - A full clear takes DEPTH cycles after rst deasserts.
- rst with CLEAR_ON_RESET=0: FSM enters RUN on the first clk edge after rst deasserts.
- In RUN, req_ready=1 every cycle and the block accepts one request per cycle with no bubbles. cs is ignored while req_ready=0; no request is queued.
- Write (accepted, addr < DEPTH): bytes with be[i]=1 are updated; other bytes keep their value. be all zero is a legal no-op write.
  - WR_RD_MODE=1: returns the pre-write word with rd_valid after RD_LATENCY cycles.
  - WR_RD_MODE=2: returns the post-write (merged) word with rd_valid after RD_LATENCY cycles.
  - WR_RD_MODE=0: no rd_valid for writes.
- Read (accepted, addr < DEPTH): array value at the accept edge appears on rdata with rd_valid=1 exactly RD_LATENCY cycles after the accept edge.
  - Latency 1: valid in the cycle after the accept edge.
  - A write to the same address one cycle later does not affect the returned value.
- Out-of-range (addr >= DEPTH):
  - Write: no array change.
  - Read (or write with WR_RD_MODE != 0): rdata=0, rd_valid=1, rd_err=1 at normal latency.
  - In-range responses have rd_err=0.
- Back-to-back accepted requests produce back-to-back rd_valid pulses, in order.
- rdata holds its last value while rd_valid=0. rd_err is low whenever rd_valid is low.
- Reset mid-operation: in-flight reads are dropped with no rd_valid. A CLEAR in progress restarts from address 0.
- RD_LATENCY=2 adds one output register stage after the array read register; both stages carry valid/err.

Decomposition:
- Package sp_ram_pkg holds:
  - FSM state enum: CLEAR, RUN.
  - WR_RD_MODE constants: WRM_NONE=0, WRM_READ_FIRST=1, WRM_WRITE_FIRST=2.
  - A function computing the byte-enable merge of old word, wdata and be.
- Sub-module sp_ram_array: bare array with one port (addr, we, per-byte write enables, wdata) and a registered read of the old or merged word. The top level owns the FSM, clear counter, range check and valid/err pipeline.

Test Plan:
1. CLEAR_ON_RESET=1, DEPTH=16: preload garbage via backdoor, pulse rst -> req_ready/init_done rise exactly 16 cycles after rst deasserts; reading all 16 addresses returns 0x0000_0000 with rd_valid each.
2. RD_LATENCY=1: write 0xDEADBEEF to addr 3 with be=4'hF, then be=4'b0010 with wdata=0x0000_5500, then read addr 3 -> rdata=0xDEAD55EF with rd_valid 1 cycle after the read accept.
3. RD_LATENCY=2: back-to-back reads of addr 0,1,2 holding 0x11,0x22,0x33 -> three consecutive rd_valid pulses 2 cycles after each accept, in order.
4. WR_RD_MODE=1 vs 2: addr 5 holds 0xAAAA_AAAA; write 0x1234_5678 with be=4'hF -> mode 1 returns 0xAAAA_AAAA, mode 2 returns 0x1234_5678; a subsequent read returns 0x1234_5678 in both modes.
5. DEPTH=12, ADDR_WIDTH=4: write to addr 13 then read addr 13 -> array unchanged, rd_valid=1, rd_err=1, rdata=0; a read of addr 11 gives rd_err=0.
6. Assert rst one cycle after a read accept with RD_LATENCY=2 -> no rd_valid emerges; clear restarts at address 0 and init_done is low until it completes.
